// File: rtl/cdb_arbiter.sv
// cdb_arbiter: four-way common data bus arbiter with round-robin priority,
// starvation-driven urgency and a registered one-cycle broadcast stage.
module cdb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int MAX_WAIT = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [3:0]             req,
    input  logic [3:0][TAG_W-1:0]  tag_i,
    input  logic [3:0][DATA_W-1:0] data_i,
    output logic [3:0]             gnt,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [DATA_W-1:0]      cdb_data
);
    logic [1:0]      ptr, idx, rr_idx, urg_idx, cand;
    logic [3:0][3:0] wait_cnt;
    logic [3:0]      urgent;

    always_comb begin
        urgent  = '0;
        rr_idx  = ptr;
        urg_idx = 2'd0;
        cand    = ptr;
        for (int i = 0; i < 4; i++) urgent[i] = req[i] && wait_cnt[i] == 4'(MAX_WAIT);
        // descending scans so the closest-to-pointer / lowest-index hit lands last
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            rr_idx = req[cand] ? cand : rr_idx;
        end
        for (int i = 3; i >= 0; i--) urg_idx = urgent[i] ? 2'(i) : urg_idx;
        idx = |urgent ? urg_idx : rr_idx;
        gnt = (rst && !flush && |req) ? 4'b0001 << idx : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= 2'd0;
            wait_cnt  <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= |gnt;
            if (|gnt) begin
                ptr      <= idx + 2'd1;
                cdb_tag  <= tag_i[idx];
                cdb_data <= data_i[idx];
            end
            for (int i = 0; i < 4; i++)
                wait_cnt[i] <= (flush || gnt[i] || !req[i]) ? 4'd0 :
                               (wait_cnt[i] == 4'(MAX_WAIT)) ? wait_cnt[i] : wait_cnt[i] + 4'd1;
        end
    end
endmodule
